mux_scan_n: RTL and testbench

- Parametrised N-channel, WIDTH-bit multiplexer with a registered output.
- Generalises the 4:1 single-bit mux in three ways: arbitrary channel count, multi-bit data, and a second mode.
- Manual mode: output follows a select input.
- Scan mode: a dwell counter walks round-robin through channels enabled in a mask.
- Sits in front of shared single-lane consumers (e.g. one display/ADC/serialiser fed by several sources).

---
 rtl/mux_scan_pkg.sv | 19 +
 rtl/mux_rr_next.sv | 49 ++++
 rtl/mux_scan_n.sv | 159 +++++++++++++++
 tb/tb_mux_scan_n.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mux_scan_pkg                                                               |
// | Shared FSM state encoding and mode constants for the mux_scan_n block.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mux_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mux_rr_next.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mux_rr_next                                                                |
// | Combinational round-robin search: next set mask bit strictly after cur,   |
// | wrapping to the lowest set bit when none is higher.                        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mux_rr_next
    import mux_scan_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int SEL_W = 2
) (
    input  logic [N_CH-1:0]  i_mask,
    input  logic [SEL_W-1:0] i_cur,
    output logic [SEL_W-1:0] o_next,
    output logic             o_wrap,
    output logic             o_any
);

    logic             w_hi_found;
    logic             w_lo_found;
    logic [SEL_W-1:0] w_hi_idx;
    logic [SEL_W-1:0] w_lo_idx;

    // Descending walk: the last hit recorded is the lowest qualifying index.
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (i_mask[k]) begin
                w_lo_found = 1'b1;
                w_lo_idx   = SEL_W'(k);
                if (k > int'(i_cur)) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = SEL_W'(k);
                end
            end
        end
    end

    assign o_next = w_hi_found ? w_hi_idx : w_lo_idx;
    assign o_wrap = w_lo_found && !w_hi_found;
    assign o_any  = w_lo_found;

endmodule
`default_nettype wire

// File: rtl/mux_scan_n.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mux_scan_n                                                                 |
// | N-channel WIDTH-bit registered mux with manual select and round-robin     |
// | dwell scan. Optional MUX_SCAN_PARITY_EN adds registered even-parity y_par. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mux_scan_n
    import mux_scan_pkg::*;
#(
    parameter  int N_CH  = 4,
    parameter  int WIDTH = 8,
    parameter  int DWELL = 4,
    localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH*WIDTH-1:0] i,
    input  logic [SEL_W-1:0]      s,
    input  logic                  mode,
    input  logic                  en,
    input  logic [N_CH-1:0]       ch_mask,
    output logic [WIDTH-1:0]      y,
    output logic                  y_valid,
    output logic [SEL_W-1:0]      cur_ch,
    output logic                  wrap
`ifdef MUX_SCAN_PARITY_EN
   ,output logic                  y_par
`endif
);

    localparam int               CNT_W        = $clog2(DWELL + 1);
    localparam logic [CNT_W-1:0] c_dwell_last = CNT_W'(DWELL - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_dwell;
    logic             r_live;
    logic [WIDTH-1:0] r_y;
    logic             r_valid;
    logic [SEL_W-1:0] r_cur;
    logic             r_wrap;

    logic [SEL_W-1:0] w_rr_next;
    logic             w_rr_wrap;
    logic             w_any;
    logic             w_cur_on;
    logic             w_entry;
    logic             w_advance;
    logic [SEL_W-1:0] w_entry_ch;
    logic [SEL_W-1:0] w_tgt;
    logic [WIDTH-1:0] w_tgt_data;
    logic             w_tgt_on;

    mux_rr_next #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_rr_next (
        .i_mask (ch_mask),
        .i_cur  (r_cur),
        .o_next (w_rr_next),
        .o_wrap (w_rr_wrap),
        .o_any  (w_any)
    );

    always_comb begin
        w_cur_on = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (int'(r_cur) == k) w_cur_on = ch_mask[k];
        end
    end

    // r_live is cleared by manual mode and by an empty mask, so the next scan
    // cycle re-enters at the lowest enabled index >= cur_ch instead of resuming.
    assign w_entry_ch = w_cur_on ? r_cur : w_rr_next;
    assign w_entry    = (r_state == MANUAL) || !r_live;
    assign w_advance  = (r_dwell == c_dwell_last);

    always_comb begin
        if (mode == MODE_MANUAL) w_tgt = s;
        else if (w_entry)        w_tgt = w_entry_ch;
        else if (w_advance)      w_tgt = w_rr_next;
        else                     w_tgt = r_cur;
    end

    // Out-of-range indices match no channel: data stays 0 and valid stays low.
    always_comb begin
        w_tgt_data = '0;
        w_tgt_on   = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (int'(w_tgt) == k) begin
                w_tgt_data = i[k*WIDTH +: WIDTH];
                w_tgt_on   = (mode == MODE_MANUAL) || ch_mask[k];
            end
        end
    end

`ifdef MUX_SCAN_PARITY_EN
    logic r_y_par;
    assign y_par = r_y_par;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_dwell <= '0;
            r_live  <= 1'b0;
            r_y     <= '0;
            r_valid <= 1'b0;
            r_cur   <= '0;
            r_wrap  <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
            r_y_par <= 1'b0;
`endif
        end else begin
            r_wrap <= 1'b0;
            if (!en) begin
                r_state <= IDLE;
            end else if (mode == MODE_SCAN && !w_any) begin
                r_state <= SCAN;
                r_dwell <= '0;
                r_live  <= 1'b0;
                r_valid <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
                r_y_par <= 1'b0;
`endif
            end else begin
                r_cur   <= w_tgt;
                r_y     <= w_tgt_data;
                r_valid <= w_tgt_on;
`ifdef MUX_SCAN_PARITY_EN
                r_y_par <= w_tgt_on & (^w_tgt_data);
`endif
                if (mode == MODE_MANUAL) begin
                    r_state <= MANUAL;
                    r_dwell <= '0;
                    r_live  <= 1'b0;
                end else begin
                    r_state <= SCAN;
                    r_live  <= 1'b1;
                    if (w_entry) begin
                        r_dwell <= '0;
                    end else if (w_advance) begin
                        r_dwell <= '0;
                        r_wrap  <= w_rr_wrap;
                    end else begin
                        r_dwell <= r_dwell + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign y       = r_y;
    assign y_valid = r_valid;
    assign cur_ch  = r_cur;
    assign wrap    = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_n.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mux_scan_n                                                              |
// | Scoreboard bench: a 4-channel and a 5-channel instance, DWELL=3.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mux_scan_n;

    typedef struct {
        logic       b;
        logic [7:0] y;
        logic       v;
        logic [2:0] c;
        logic       w;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        mode = 1'b0;
    logic [2:0]  s = 3'd0;
    logic [4:0]  mask = 5'd0;
    logic [31:0] i_a = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    logic [39:0] i_b = {8'hE4, 8'hD3, 8'hC2, 8'hB1, 8'hA0};
    logic [7:0]  d3_next = 8'hD3;

    logic [7:0]  y_a, y_b;
    logic        v_a, v_b, w_a, w_b;
    logic [1:0]  c_a;
    logic [2:0]  c_b;
`ifdef MUX_SCAN_PARITY_EN
    logic        p_a, p_b;
`endif

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mux_scan_n #(.N_CH(4), .WIDTH(8), .DWELL(3)) dut_a (
        .clk(clk), .rst(rst), .i(i_a), .s(s[1:0]), .mode(mode), .en(en),
        .ch_mask(mask[3:0]), .y(y_a), .y_valid(v_a), .cur_ch(c_a), .wrap(w_a)
`ifdef MUX_SCAN_PARITY_EN
       ,.y_par(p_a)
`endif
    );

    mux_scan_n #(.N_CH(5), .WIDTH(8), .DWELL(3)) dut_b (
        .clk(clk), .rst(rst), .i(i_b), .s(s), .mode(mode), .en(en),
        .ch_mask(mask), .y(y_b), .y_valid(v_b), .cur_ch(c_b), .wrap(w_b)
`ifdef MUX_SCAN_PARITY_EN
       ,.y_par(p_b)
`endif
    );

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, req);
        end
    endtask

    // Inputs change on the falling edge; the expectation is for the next rising edge.
    task automatic cyc(input logic e_v, input logic m_v, input logic [2:0] s_v,
                       input logic [4:0] k_v, input logic b_v, input logic [7:0] ey,
                       input logic ev, input logic [2:0] ec, input logic ew);
        exp_t e;
        @(negedge clk);
        en   = e_v;
        mode = m_v;
        s    = s_v;
        mask = k_v;
        i_a[31:24] = d3_next;
        e.b = b_v; e.y = ey; e.v = ev; e.c = ec; e.w = ew;
        sb.push_back(e);
    endtask

    // Monitor: one expectation is consumed per rising edge, sampled 1 time unit later.
    initial begin
        exp_t       e;
        logic [7:0] ay;
        logic       av, aw;
        logic [2:0] ac;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (!e.b) begin
                    ay = y_a; av = v_a; ac = {1'b0, c_a}; aw = w_a;
                end else begin
                    ay = y_b; av = v_b; ac = c_b; aw = w_b;
                end
                chk(e.b ? "y_b" : "y_a", ay, e.y);
                chk(e.b ? "y_valid_b" : "y_valid_a", {7'd0, av}, {7'd0, e.v});
                chk(e.b ? "cur_ch_b" : "cur_ch_a", {5'd0, ac}, {5'd0, e.c});
                chk(e.b ? "wrap_b" : "wrap_a", {7'd0, aw}, {7'd0, e.w});
`ifdef MUX_SCAN_PARITY_EN
                chk(e.b ? "y_par_b" : "y_par_a", {7'd0, e.b ? p_b : p_a},
                    {7'd0, e.v & (^e.y)});
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        en = 1'b1; mode = 1'b0; s = 3'd2;
        #1 rst = 1'b1;
        cyc(1'b1, 1'b0, 3'd2, 5'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
        @(posedge clk); #3 rst = 1'b0;
        // Manual mode, one-cycle latency
        cyc(1'b1, 1'b0, 3'd2, 5'h00, 1'b0, 8'hC2, 1'b1, 3'd2, 1'b0);
        cyc(1'b1, 1'b0, 3'd0, 5'h00, 1'b0, 8'hA0, 1'b1, 3'd0, 1'b0);
        cyc(1'b1, 1'b0, 3'd1, 5'h00, 1'b0, 8'hB1, 1'b1, 3'd1, 1'b0);
        d3_next = 8'h01;
        cyc(1'b1, 1'b0, 3'd3, 5'h00, 1'b0, 8'h01, 1'b1, 3'd3, 1'b0);
        d3_next = 8'hD3;
        cyc(1'b1, 1'b0, 3'd3, 5'h00, 1'b0, 8'hD3, 1'b1, 3'd3, 1'b0);
        cyc(1'b1, 1'b0, 3'd0, 5'h00, 1'b0, 8'hA0, 1'b1, 3'd0, 1'b0);
        // Scan walk over mask 1011
        repeat (3) cyc(1'b1, 1'b1, 3'd0, 5'b01011, 1'b0, 8'hA0, 1'b1, 3'd0, 1'b0);
        repeat (3) cyc(1'b1, 1'b1, 3'd0, 5'b01011, 1'b0, 8'hB1, 1'b1, 3'd1, 1'b0);
        repeat (3) cyc(1'b1, 1'b1, 3'd0, 5'b01011, 1'b0, 8'hD3, 1'b1, 3'd3, 1'b0);
        cyc(1'b1, 1'b1, 3'd0, 5'b01011, 1'b0, 8'hA0, 1'b1, 3'd0, 1'b1);
        repeat (2) cyc(1'b1, 1'b1, 3'd0, 5'b01011, 1'b0, 8'hA0, 1'b1, 3'd0, 1'b0);
        cyc(1'b1, 1'b1, 3'd0, 5'b01011, 1'b0, 8'hB1, 1'b1, 3'd1, 1'b0);
        // Empty mask freezes, then a single-bit mask
        repeat (3) cyc(1'b1, 1'b1, 3'd0, 5'b00000, 1'b0, 8'hB1, 1'b0, 3'd1, 1'b0);
        repeat (3) cyc(1'b1, 1'b1, 3'd0, 5'b00100, 1'b0, 8'hC2, 1'b1, 3'd2, 1'b0);
        cyc(1'b1, 1'b1, 3'd0, 5'b00100, 1'b0, 8'hC2, 1'b1, 3'd2, 1'b1);
        repeat (2) cyc(1'b1, 1'b1, 3'd0, 5'b00100, 1'b0, 8'hC2, 1'b1, 3'd2, 1'b0);
        cyc(1'b1, 1'b1, 3'd0, 5'b00100, 1'b0, 8'hC2, 1'b1, 3'd2, 1'b1);
        // Current channel removed mid-dwell
        repeat (2) cyc(1'b1, 1'b1, 3'd0, 5'b01001, 1'b0, 8'hC2, 1'b0, 3'd2, 1'b0);
        repeat (2) cyc(1'b1, 1'b1, 3'd0, 5'b01001, 1'b0, 8'hD3, 1'b1, 3'd3, 1'b0);
        // Mode switch, then enable freeze and resume
        cyc(1'b1, 1'b0, 3'd1, 5'b01001, 1'b0, 8'hB1, 1'b1, 3'd1, 1'b0);
        repeat (2) cyc(1'b1, 1'b1, 3'd1, 5'b01001, 1'b0, 8'hD3, 1'b1, 3'd3, 1'b0);
        repeat (5) cyc(1'b0, 1'b0, 3'd2, 5'b01001, 1'b0, 8'hD3, 1'b1, 3'd3, 1'b0);
        cyc(1'b1, 1'b1, 3'd2, 5'b01001, 1'b0, 8'hD3, 1'b1, 3'd3, 1'b0);
        cyc(1'b1, 1'b1, 3'd2, 5'b01001, 1'b0, 8'hA0, 1'b1, 3'd0, 1'b1);
        cyc(1'b1, 1'b1, 3'd2, 5'b01001, 1'b0, 8'hA0, 1'b1, 3'd0, 1'b0);
        // Reset mid-scan, restart at lowest enabled channel
        @(posedge clk); #3 rst = 1'b1;
        cyc(1'b1, 1'b1, 3'd0, 5'b01010, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
        @(posedge clk); #3 rst = 1'b0;
        cyc(1'b1, 1'b1, 3'd0, 5'b01010, 1'b0, 8'hB1, 1'b1, 3'd1, 1'b0);
        // Five-channel instance: illegal selects and scan from an out-of-range index
        cyc(1'b1, 1'b0, 3'd6, 5'b00000, 1'b1, 8'h00, 1'b0, 3'd6, 1'b0);
        cyc(1'b1, 1'b0, 3'd4, 5'b00000, 1'b1, 8'hE4, 1'b1, 3'd4, 1'b0);
        cyc(1'b1, 1'b0, 3'd5, 5'b00000, 1'b1, 8'h00, 1'b0, 3'd5, 1'b0);
        repeat (3) cyc(1'b1, 1'b1, 3'd5, 5'b10010, 1'b1, 8'hB1, 1'b1, 3'd1, 1'b0);
        repeat (3) cyc(1'b1, 1'b1, 3'd5, 5'b10010, 1'b1, 8'hE4, 1'b1, 3'd4, 1'b0);
        cyc(1'b1, 1'b1, 3'd5, 5'b10010, 1'b1, 8'hB1, 1'b1, 3'd1, 1'b1);

        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
